demux_stream: RTL
=================

Name: demux_stream

Overview:
- Parametrised 1-to-NUM_CH registered demultiplexer; successor to the 2-output combinational demux.
- Routes DATA_W-bit words to the output channel named by a select field, using valid/ready handshakes on the input and on every output.
- Each output channel has a one-entry holding register, so a stalled channel does not corrupt data on the others.
- Out-of-range selects are dropped, flagged and counted. Sits between a single producer and NUM_CH independent consumers.

Parameters:
- DATA_W, 8: payload width in bits.
- NUM_CH, 4: number of output channels, range 2..16.
- SEL_W, 2: select width; must satisfy 2**SEL_W >= NUM_CH.
- CNT_W, 8: width of the drop counter.

Ports:
- clk, in, 1: single clock; every flop is rising-edge.
- rst, in, 1: reset, synchronous and active-high.
- in_valid, in, 1: input word present.
- in_ready, out, 1: block accepts the word this cycle.
- in_data, in, DATA_W: input payload.
- in_sel, in, SEL_W: destination channel index.
- out_valid, out, NUM_CH: bit k set means channel k holds a word.
- out_ready, in, NUM_CH: bit k set means consumer k takes the word.
- out_data, out, NUM_CH*DATA_W: channel k payload sits at bits [k*DATA_W +: DATA_W].
- err_sel, out, 1: one-cycle pulse when an out-of-range word is dropped.
- drop_count, out, CNT_W: saturating count of dropped words.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While rst=1 at a rising edge, the following are cleared: out_valid=0, out_data=0, err_sel=0, drop_count=0.
- Reset mid-operation: held words are discarded and no handshake completes in that cycle.
- Channel full flag: full[k] = out_valid[k].
- in_ready is combinational from in_sel and out_ready:
  - sel_ok = (in_sel < NUM_CH).
  - If sel_ok: in_ready = !full[in_sel] | out_ready[in_sel].
  - If !sel_ok: in_ready = 1; out-of-range words are never stalled.
- Accept: in_valid & in_ready & sel_ok. On the next edge, out_data[in_sel] <= in_data and out_valid[in_sel] <= 1. Latency from input handshake to out_valid is 1 cycle.
- Drain: out_valid[k] & out_ready[k]. On the next edge, out_valid[k] <= 0 unless the same cycle also accepts into k.
- Simultaneous drain and accept on channel k: the new word replaces the old one, out_valid[k] stays 1, and there is no bubble. A channel sustains one word per cycle.
- Stability: while out_valid[k] & !out_ready[k], out_data[k] and out_valid[k] are held unchanged.
- Channel independence: channels other than in_sel are unaffected by an accept, and drain independently in the same cycle.
- Invalid select: in_valid & !sel_ok.
  - No channel is written.
  - err_sel = 1 for exactly the next cycle.
  - drop_count increments by 1 and saturates at 2**CNT_W-1 (no wrap).
- in_valid = 0: no state change except drains. in_data and in_sel are don't-care.
- out_data of an empty channel holds its last value. Consumers must qualify it with out_valid.
- There are no combinational paths from in_valid or in_data to any output.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, in_sel=1 -> out_valid=0000, drop_count=0, err_sel=0. Release and send 0xA5 to sel 1 with out_ready=1111 -> out_valid=0010 one cycle later with ch1=0xA5, then out_valid=0000.
- Fan-out sweep, NUM_CH=4, all out_ready=1: send 0x10, 0x11, 0x12, 0x13 to sel 0..3 on back-to-back cycles -> each word appears on its own channel exactly 1 cycle after acceptance; in_ready stays 1 throughout.
- Backpressure: out_ready[2]=0 and send 0x55 to sel 2 -> ch2 holds 0x55. A second word 0x66 to sel 2 -> in_ready=0 and ch2 stays 0x55. Meanwhile 0x77 to sel 0 is accepted. Raise out_ready[2] -> 0x66 is accepted in that same cycle and ch2 = 0x66 on the next edge, with no bubble.
- Invalid select, NUM_CH=3, SEL_W=2: send sel=3 data 0xFF -> in_ready=1, err_sel pulses for 1 cycle, drop_count=1, out_valid unchanged.
- Saturation, CNT_W=2: send 5 invalid words -> drop_count sequence 1, 2, 3, 3, 3.
- Reset mid-stream: ch1 and ch3 full and stalled, assert rst for 1 cycle -> out_valid=0000. Next accepted word 0x42 to sel 3 -> ch3 = 0x42 and no stale words reappear.

Source files
------------

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-NUM_CH stream demultiplexer.
// Each channel owns a one-entry holding register. Words whose select is out of
// range are dropped, reported with a one-cycle err_sel pulse and counted.
module demux_stream #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     err_sel,
    output logic [CNT_W-1:0]         drop_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_CH-1:0]        valid_q, valid_d;
    logic [NUM_CH*DATA_W-1:0] data_q, data_d;
    logic                     err_q, err_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     sel_ok;
    logic                     accept;

    // Select decode and input readiness; channel matching is done by loop so an
    // out-of-range select never indexes past the channel vectors.
    always_comb begin
        sel_ok   = (32'(in_sel) < NUM_CH);
        in_ready = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (32'(in_sel) == k) begin
                in_ready = !valid_q[k] || out_ready[k];
            end
        end
        accept = in_valid && in_ready && sel_ok;
    end

    // Next state: drain, then accept overrides so drain+accept replaces the word
    // without a bubble; drop flag and saturating drop counter.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (valid_q[k] && out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
            if (accept && (32'(in_sel) == k)) begin
                valid_d[k]                  = 1'b1;
                data_d[k*DATA_W +: DATA_W]  = in_data;
            end
        end
        err_d = in_valid && !sel_ok;
        cnt_d = cnt_q;
        if (err_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset; reset discards held words.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign err_sel    = err_q;
    assign drop_count = cnt_q;

endmodule
